// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - fetch-stage program counter with window wrap, redirects and a return-address stack
module pc_seq #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   BASE_ADDR = 'h940,
  parameter int                 WINDOW    = 1024,
  parameter int                 STEP      = 1,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         call,
  input  logic                         ret,
  input  logic [WIDTH-1:0]             target,
  output logic [WIDTH-1:0]             Address,
  output logic                         wrap,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         fault
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] LAST = BASE_ADDR + WIDTH'(WINDOW - STEP);
  localparam logic [WIDTH-1:0] TOP  = BASE_ADDR + WIDTH'(WINDOW - 1);
  localparam logic [PW:0]      FULL = (PW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    wp;
  logic             at_last;
  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] offset;
  logic             legal;
  logic             push;

  // Wrap is a compare against LAST so a window near the top of the address space still behaves
  assign at_last  = (Address == LAST);
  assign seq_addr = at_last ? BASE_ADDR : Address + WIDTH'(STEP);
  assign offset   = target - BASE_ADDR;
  assign legal    = (target >= BASE_ADDR) && (target <= TOP) &&
                    ((offset % WIDTH'(STEP)) == '0);
  assign push     = !stall && !ret && call;

  // Circular buffer: wp points one past the top; when full it points at the oldest entry
  always_ff @(posedge clk) begin
    if (push)
      stack[wp] <= seq_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Address   <= BASE_ADDR;
      wp        <= '0;
      ras_count <= '0;
      wrap      <= 1'b0;
      ras_ovf   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      wrap    <= 1'b0;
      ras_ovf <= 1'b0;
      if (stall) begin
        Address <= Address;
      end else if (ret) begin
        if (ras_count != '0) begin
          Address   <= stack[wp - 1'b1];
          wp        <= wp - 1'b1;
          ras_count <= ras_count - 1'b1;
        end else begin
          Address <= seq_addr;
          wrap    <= at_last;
          fault   <= 1'b1;
        end
      end else if (call || branch) begin
        if (call) begin
          wp <= wp + 1'b1;
          if (ras_count == FULL)
            ras_ovf <= 1'b1;
          else
            ras_count <= ras_count + 1'b1;
        end
        if (legal) begin
          Address <= target;
        end else begin
          Address <= seq_addr;
          wrap    <= at_last;
          fault   <= 1'b1;
        end
      end else begin
        Address <= seq_addr;
        wrap    <= at_last;
      end
    end
  end
endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed bench for pc_seq with a queue-based reference model
module tb_pc_seq;
  localparam int          W      = 32;
  localparam logic [31:0] BASE   = 32'h940;
  localparam int          WINDOW = 1024;
  localparam int          STEP   = 1;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch, call, ret;
  logic [31:0] target;
  logic [31:0] Address;
  logic        wrap;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        fault;

  always #5 clk = ~clk;

  pc_seq #(.WIDTH(W), .BASE_ADDR(BASE), .WINDOW(WINDOW), .STEP(STEP), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch(branch), .call(call), .ret(ret),
    .target(target), .Address(Address), .wrap(wrap), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .fault(fault)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_addr;
  logic [31:0] m_q[$];
  bit          m_wrap, m_ovf, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_seq(input logic [31:0] a);
    return BASE + ((a - BASE + STEP) % WINDOW);
  endfunction

  function automatic bit is_legal(input logic [31:0] t);
    return (t >= BASE) && ((t - BASE) < WINDOW) && (((t - BASE) % STEP) == 0);
  endfunction

  task automatic advance();
    m_wrap = ((m_addr - BASE + STEP) >= WINDOW);
    m_addr = next_seq(m_addr);
  endtask

  task automatic redirect(input logic [31:0] t);
    if (is_legal(t)) m_addr = t;
    else begin
      advance();
      m_fault = 1'b1;
    end
  endtask

  task automatic model_edge(input bit s, input bit b, input bit c, input bit r, input logic [31:0] t);
    m_wrap = 1'b0;
    m_ovf  = 1'b0;
    if (s) begin
    end else if (r) begin
      if (m_q.size() > 0) m_addr = m_q.pop_back();
      else begin
        advance();
        m_fault = 1'b1;
      end
    end else if (c) begin
      m_q.push_back(next_seq(m_addr));
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
      redirect(t);
    end else if (b) begin
      redirect(t);
    end else begin
      advance();
    end
  endtask

  task automatic model_reset();
    m_addr = BASE;
    m_q.delete();
    m_wrap = 1'b0;
    m_ovf = 1'b0;
    m_fault = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr", Address, m_addr);
      chk("wrap", {31'b0, wrap}, {31'b0, m_wrap});
      chk("ras_count", {29'b0, ras_count}, m_q.size());
      chk("ras_ovf", {31'b0, ras_ovf}, {31'b0, m_ovf});
      chk("fault", {31'b0, fault}, {31'b0, m_fault});
    end
  end

  task automatic step(input bit s, input bit b, input bit c, input bit r, input logic [31:0] t);
    stall = s; branch = b; call = c; ret = r; target = t;
    @(posedge clk);
    model_edge(s, b, c, r, t);
    @(negedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_addr"}, Address, 32'h940);
    chk({tag, "_count"}, {29'b0, ras_count}, 32'd0);
    chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
    chk({tag, "_wrap"}, {31'b0, wrap}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ras_ovf}, 32'd0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    #1;
    reset_checks(tag);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 0; branch = 0; call = 0; ret = 0; target = '0;
    model_reset();
    #12;
    reset_checks("reset");
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    #1;

    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("count_seq", Address, 32'h940 + i);
    end
    chk("count_fault", {31'b0, fault}, 32'd0);

    step(0, 1, 0, 0, 32'hD3D);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("at_last", Address, 32'hD3F);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", Address, 32'h940);
    chk("wrap_pulse", {31'b0, wrap}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("wrap_drop", {31'b0, wrap}, 32'd0);

    step(1, 1, 1, 0, 32'h950);
    chk("stall_addr", Address, 32'h941);
    chk("stall_count", {29'b0, ras_count}, 32'd0);

    step(0, 1, 0, 0, 32'h950);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 32'h960 + 32'(16 * k));
      if (k == 3) chk("call4_ovf", {31'b0, ras_ovf}, 32'd0);
    end
    chk("call5_ovf", {31'b0, ras_ovf}, 32'd1);
    chk("call5_count", {29'b0, ras_count}, 32'd4);
    chk("call5_addr", Address, 32'h9A0);

    step(0, 0, 0, 1, 0); chk("ret1", Address, 32'h991);
    step(0, 0, 0, 1, 0); chk("ret2", Address, 32'h981);
    step(0, 0, 0, 1, 0); chk("ret3", Address, 32'h971);
    step(0, 0, 0, 1, 0); chk("ret4", Address, 32'h961);
    chk("ret4_fault", {31'b0, fault}, 32'd0);
    step(0, 0, 0, 1, 0);
    chk("underflow_addr", Address, 32'h962);
    chk("underflow_fault", {31'b0, fault}, 32'd1);

    step(0, 0, 1, 0, 32'h970);
    step(0, 1, 0, 1, 32'h980);
    chk("ret_over_branch", Address, 32'h963);

    async_reset("reset2");
    step(0, 1, 0, 0, 32'h9A0);
    step(0, 1, 0, 0, 32'h100);
    chk("illegal_addr", Address, 32'h9A1);
    chk("illegal_fault", {31'b0, fault}, 32'd1);

    step(0, 0, 1, 0, 32'h9F0);
    step(0, 0, 1, 0, 32'hA00);
    chk("pre_reset_addr", Address, 32'hA00);
    chk("pre_reset_count", {29'b0, ras_count}, 32'd2);
    async_reset("midrun");
    step(0, 0, 0, 0, 0);
    chk("post_reset_addr", Address, 32'h941);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
